// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler.
package display_pkg;

  // State encoding matches the src code each state shows.
  typedef enum logic [1:0] {
    ST_TEMP  = 2'b00,
    ST_SET   = 2'b01,
    ST_EDIT  = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  localparam logic [1:0] SRC_TEMP  = 2'b00;
  localparam logic [1:0] SRC_SET   = 2'b01;
  localparam logic [1:0] SRC_EDIT  = 2'b10;
  localparam logic [1:0] SRC_ALARM = 2'b11;

  localparam logic [7:0] DISP_MAX = 8'd99;

  // Clamp a value to what the 2-digit display can show.
  function automatic logic [7:0] sat_disp(input logic [7:0] v);
    return (v > DISP_MAX) ? DISP_MAX : v;
  endfunction

  // Source code reported for a given state.
  function automatic logic [1:0] src_of(input state_e s);
    logic [1:0] code;
    case (s)
      ST_TEMP:  code = SRC_TEMP;
      ST_SET:   code = SRC_SET;
      ST_EDIT:  code = SRC_EDIT;
      default:  code = SRC_ALARM;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/display_scheduler_tick_counter.sv
// Wrap counter 0..LIMIT-1 with synchronous clear and a combinational wrap pulse.
module tick_counter #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_c_o
);

  // A limit of 0 is treated as 1 so the counter is always well formed.
  localparam int unsigned LIM_C = (LIMIT < 1) ? 1 : LIMIT;
  localparam int unsigned CW    = (LIM_C > 1) ? $clog2(LIM_C) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIM_C - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_c_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, then wrap, then increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_c_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Chooses what the 2-digit display shows: rotating temp/setpoint, edit or alarm with blink.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temp_in,
  input  logic [7:0] set_in,
  input  logic       edit_req,
  input  logic       alarm,
  output logic [7:0] disp_num,
  output logic       disp_blank,
  output logic [1:0] src
);

  state_e     state_q, state_d;
  logic       phase_q, phase_d;       // 1 = segments visible
  logic [7:0] disp_num_d;
  logic       disp_blank_d;
  logic [1:0] src_d;
  logic       rotating, blinking, state_chg;
  logic       dwell_wrap, blink_wrap;

  assign rotating  = (state_q == ST_TEMP) || (state_q == ST_SET);
  assign blinking  = !rotating;
  assign state_chg = (state_d != state_q);

  tick_counter #(.LIMIT(DWELL_CYCLES)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_chg),
    .en_i     (rotating),
    .wrap_c_o (dwell_wrap)
  );

  tick_counter #(.LIMIT(BLINK_CYCLES)) u_blink (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_chg),
    .en_i     (blinking),
    .wrap_c_o (blink_wrap)
  );

  // Next state, blink phase and output values from the current state and inputs.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    disp_num_d   = 8'd0;
    disp_blank_d = 1'b0;
    src_d        = src_of(state_q);

    if (alarm) begin
      state_d = ST_ALARM;
    end else begin
      case (state_q)
        ST_TEMP:  if (edit_req) state_d = ST_EDIT; else if (dwell_wrap) state_d = ST_SET;
        ST_SET:   if (edit_req) state_d = ST_EDIT; else if (dwell_wrap) state_d = ST_TEMP;
        ST_EDIT:  if (!edit_req) state_d = ST_TEMP;
        default:  state_d = edit_req ? ST_EDIT : ST_TEMP;
      endcase
    end

    if (state_d != state_q) begin
      phase_d = 1'b1;
    end else if (blink_wrap) begin
      phase_d = !phase_q;
    end

    if ((state_q == ST_TEMP) || (state_q == ST_ALARM)) begin
      disp_num_d = sat_disp(temp_in);
    end else begin
      disp_num_d = sat_disp(set_in);
    end

    disp_blank_d = blinking ? !phase_q : 1'b0;
  end

  // State, blink phase and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_TEMP;
      phase_q    <= 1'b1;
      disp_num   <= 8'd0;
      disp_blank <= 1'b1;
      src        <= SRC_TEMP;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      disp_num   <= disp_num_d;
      disp_blank <= disp_blank_d;
      src        <= src_d;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (DWELL_CYCLES=4, BLINK_CYCLES=2, plus a DWELL=1 instance).
module tb_display_scheduler;

  typedef struct {
    logic       rst;
    logic [7:0] temp;
    logic [7:0] setp;
    logic       edit;
    logic       alm;
    logic [7:0] e_num;
    logic       e_blank;
    logic [1:0] e_src;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] temp_in, set_in;
  logic       edit_req, alarm;
  logic [7:0] disp_num;
  logic       disp_blank;
  logic [1:0] src;

  logic       rst1;
  logic [7:0] temp1, set1;
  logic       edit1, alarm1;
  logic [7:0] disp_num1;
  logic       disp_blank1;
  logic [1:0] src1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  display_scheduler #(.DWELL_CYCLES(4), .BLINK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .temp_in    (temp_in),
    .set_in     (set_in),
    .edit_req   (edit_req),
    .alarm      (alarm),
    .disp_num   (disp_num),
    .disp_blank (disp_blank),
    .src        (src)
  );

  display_scheduler #(.DWELL_CYCLES(1), .BLINK_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .temp_in    (temp1),
    .set_in     (set1),
    .edit_req   (edit1),
    .alarm      (alarm1),
    .disp_num   (disp_num1),
    .disp_blank (disp_blank1),
    .src        (src1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] t, input logic [7:0] s, input logic e,
                     input logic a, input logic [7:0] n, input logic b, input logic [1:0] sr,
                     input int reps);
    vec_t v;
    v.rst = r; v.temp = t; v.setp = s; v.edit = e; v.alm = a;
    v.e_num = n; v.e_blank = b; v.e_src = sr;
    for (int k = 0; k < reps; k++) vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] n, input logic b, input logic [1:0] s);
    check({tag, " num"},   disp_num, n);
    check({tag, " blank"}, 8'(disp_blank), 8'(b));
    check({tag, " src"},   8'(src), 8'(s));
  endtask

  initial begin
    rst1 = 1'b1; temp1 = 8'd25; set1 = 8'd30; edit1 = 1'b0; alarm1 = 1'b0;

    //   rst temp set  ed al   num blk src reps
    add(1, 25,  30,  0, 0,   0, 1, 0, 2);   // held in reset
    add(0, 25,  30,  0, 0,  25, 0, 0, 4);   // TEMP dwell
    add(0, 25,  30,  0, 0,  30, 0, 1, 4);   // SET dwell
    add(0, 25,  30,  0, 0,  25, 0, 0, 1);
    add(0, 26,  30,  0, 0,  26, 0, 0, 3);   // temp change mid-dwell
    add(0, 25,  30,  0, 0,  30, 0, 1, 1);
    add(0, 25,  30,  1, 0,  30, 0, 1, 1);   // edit request sampled
    add(0, 25,  30,  1, 0,  30, 0, 2, 2);   // EDIT visible
    add(0, 25,  30,  1, 0,  30, 1, 2, 2);   // EDIT blanked
    add(0, 25,  30,  1, 0,  30, 0, 2, 1);
    add(0, 25,  30,  0, 0,  30, 0, 2, 1);   // edit released
    add(0, 25,  30,  0, 0,  25, 0, 0, 4);   // fresh TEMP dwell
    add(0, 25,  30,  0, 0,  30, 0, 1, 1);
    add(0, 85,  30,  1, 1,  30, 0, 1, 1);   // alarm + edit together
    add(0, 85,  30,  1, 1,  85, 0, 3, 2);
    add(0, 85,  30,  1, 1,  85, 1, 3, 2);
    add(0, 85,  30,  1, 0,  85, 0, 3, 1);   // alarm drops, edit held
    add(0, 85,  30,  1, 0,  30, 0, 2, 2);   // EDIT restarts visible
    add(0, 85,  30,  1, 0,  30, 1, 2, 1);
    add(0, 200, 150, 1, 0,  99, 1, 2, 1);   // saturation in EDIT
    add(0, 200, 150, 0, 0,  99, 0, 2, 1);
    add(0, 200, 150, 0, 0,  99, 0, 0, 1);   // saturation in TEMP
    add(0, 200, 150, 0, 1,  99, 0, 0, 1);
    add(0, 200, 150, 0, 1,  99, 0, 3, 2);   // saturation in ALARM
    add(0, 200, 150, 0, 1,  99, 1, 3, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      temp_in  = vecs[i].temp;
      set_in   = vecs[i].setp;
      edit_req = vecs[i].edit;
      alarm    = vecs[i].alm;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_num, vecs[i].e_blank, vecs[i].e_src);
    end

    // Asynchronous reset between edges while in ALARM.
    #3 rst = 1'b1;
    #1 check_outs("async_rst", 8'd0, 1'b1, 2'd0);
    alarm = 1'b0; edit_req = 1'b0; temp_in = 8'd25; set_in = 8'd30;
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 check_outs($sformatf("post_rst_temp%0d", k), 8'd25, 1'b0, 2'd0);
    end
    @(posedge clk);
    #1 check_outs("post_rst_set", 8'd30, 1'b0, 2'd1);

    // DWELL_CYCLES=1 alternates every cycle.
    check("d1_rst_num", disp_num1, 8'd0);
    rst1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("d1_src%0d", k),   8'(src1), 8'(k % 2));
      check($sformatf("d1_num%0d", k),   disp_num1, (k % 2 == 0) ? 8'd25 : 8'd30);
      check($sformatf("d1_blank%0d", k), 8'(disp_blank1), 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 50_000_000, clock cycles each value shows in rotation mode.
REQ-002 Parameter BLINK_CYCLES, default 12_500_000, clock cycles per blink half-period.
REQ-003 Port clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous and active-high.
REQ-005 Port temp_in  in  8  measured temperature, unsigned.
REQ-006 Port set_in  in  8  temperature setpoint, unsigned.
REQ-007 Port edit_req  in  1  level: the user is editing the setpoint.
REQ-008 Port alarm  in  1  level: over-temperature alarm.
REQ-009 Port disp_num  out  8  value for the 2-digit display driver, always 0..99.
REQ-010 Port disp_blank  out  1  drives the display driver enable; 1 = all segments off.
REQ-011 Port src  out  2  shown source: 00 temp, 01 setpoint, 10 edit, 11 alarm.

Function
REQ-012 The FSM SHALL have four states: TEMP, SET, EDIT, ALARM.
REQ-013 Priority SHALL be alarm > edit_req > rotation; alarm and edit_req high in the same cycle SHALL select ALARM.
REQ-014 In TEMP or SET, the FSM SHALL move to the other state once the dwell counter reaches DWELL_CYCLES-1, and the dwell counter SHALL restart at 0.
REQ-015 edit_req high in TEMP or SET SHALL enter EDIT on the next edge; edit_req low in EDIT SHALL enter TEMP.
REQ-016 alarm high in any state SHALL enter ALARM on the next edge; alarm low in ALARM SHALL enter EDIT if edit_req is high, otherwise TEMP.
REQ-017 Every state change SHALL clear both the dwell counter and the blink counter, and the blink phase SHALL become visible.
REQ-018 In EDIT and ALARM, the blink counter SHALL count 0..BLINK_CYCLES-1, and the phase SHALL toggle on wrap.
REQ-019 The blink phase SHALL always start visible: BLINK_CYCLES cycles on, then BLINK_CYCLES cycles off.
REQ-020 The displayed value SHALL be temp_in in TEMP and ALARM, and set_in in SET and EDIT.
REQ-021 Any displayed value above 99 SHALL saturate to 99.
REQ-022 disp_blank SHALL be 0 in TEMP and SET, and equal the inverted blink phase in EDIT and ALARM.
REQ-023 disp_num, disp_blank and src SHALL be registered.
REQ-024 Outputs SHALL reflect the state and inputs sampled at the previous edge (1-cycle latency).
REQ-025 Input changes within a state SHALL appear on disp_num after 1 cycle, without a state change.
REQ-026 Both counters SHALL be wide enough for their parameter, and both parameters SHALL be at least 1.
REQ-027 With DWELL_CYCLES=1, the FSM SHALL alternate TEMP/SET every cycle.

Reset
REQ-028 While rst is high: state TEMP, both counters 0, blink phase visible, disp_num 0, disp_blank 1, src 00.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, regardless of clk.
REQ-030 After release, the first edge SHALL start normal operation from TEMP.
REQ-031 No output SHALL be X or Z after reset.

Structure
REQ-032 Shared package display_pkg SHALL hold the state enum, the src codes (SRC_TEMP, SRC_SET, SRC_EDIT, SRC_ALARM) and the constant DISP_MAX=99.
REQ-033 One sub-module, tick_counter, SHALL be instantiated twice (dwell and blink).
REQ-034 tick_counter SHALL be a parameterised wrap counter with synchronous clear and a wrap pulse.
REQ-035 display_scheduler SHALL feed the existing 2-digit display driver directly: disp_num to its number input, disp_blank to its enable.

Verification (DWELL_CYCLES=4, BLINK_CYCLES=2)
REQ-036 Reset, then temp_in=25, set_in=30, no requests -> src/disp_num sequence 00/25 x4, 01/30 x4, 00/25 repeating; disp_blank 0 throughout.
REQ-037 edit_req high at the 2nd SET cycle -> next cycle src 10, disp_num 30; disp_blank 0,0,1,1,0,0…; edit_req low -> src 00 with a fresh 4-cycle dwell.
REQ-038 alarm and edit_req rise together, temp_in=85 -> src 11, disp_num 85, blinking; alarm low with edit_req high -> src 10, starting visible.
REQ-039 temp_in=200, set_in=150 -> disp_num 99 in every state.
REQ-040 rst pulse asserted between clock edges in ALARM -> outputs 0/1/00 immediately, without a clk edge; TEMP resumes after release.
REQ-041 temp_in changes 25→26 mid-dwell -> disp_num 26 one cycle later; dwell count unaffected.
